// File: rtl/icap_reg_reader_spartan6.sv
// -----------------------------------------------------------------------------
// icap_reg_reader_spartan6
//
// Reads one Spartan-6 configuration register (STAT, BOOTSTS, GENERAL1..5, ...)
// through the ICAP. This is the read-side partner of the multiboot writer.
// The block syncs the ICAP, sends a Type-1 read header for REG_ADDR, and
// switches the port to read mode. It captures one 16-bit word, then
// desyncs the ICAP.
//
// Ports
//   CLK         ICAP clock (same clock as the multiboot writer, <= 20 MHz)
//   MBT_RESET   synchronous active-high reset
//   RD_REQ      start request, sampled only while idle
//   REG_ADDR    configuration register address, latched on acceptance
//   BUSY        high from the cycle after acceptance until DONE
//   DONE        one-cycle pulse; RD_DATA is valid here and holds until the
//               next DONE
//   RD_DATA     captured register value in normal bit order
//   ICAP_CE     ICAP CE, active low (registered)
//   ICAP_WRITE  ICAP WRITE, 0 = write, 1 = read (registered)
//   ICAP_I      ICAP data in, bits reversed within each byte (registered)
//   ICAP_O      ICAP data out, bits reversed within each byte
//
// Parameter
//   RD_WAIT     cycles CE is held low in read mode before O is captured (1..15)
//
// Build option
//   ICAP_INST_EN  when defined, an ICAP_SPARTAN6 primitive is instantiated
//                 inside this block and fed from the registered pins. Its O
//                 output is the capture source and the ICAP_O port is ignored.
//                 The ICAP_* outputs still mirror the pins for debug.
// -----------------------------------------------------------------------------
module icap_reg_reader_spartan6 #(
   parameter int RD_WAIT = 3
) (
   input  logic        CLK,
   input  logic        MBT_RESET,
   input  logic        RD_REQ,
   input  logic [5:0]  REG_ADDR,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] RD_DATA,
   output logic        ICAP_CE,
   output logic        ICAP_WRITE,
   output logic [15:0] ICAP_I,
   input  logic [15:0] ICAP_O
);

   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

   typedef enum logic [4:0] {
      ST_IDLE    = 5'd0,
      ST_DUMMY   = 5'd1,
      ST_SYNC1   = 5'd2,
      ST_SYNC2   = 5'd3,
      ST_NOOP_A  = 5'd4,
      ST_HDR     = 5'd5,
      ST_NOOP_B  = 5'd6,
      ST_NOOP_C  = 5'd7,
      ST_ABORT1  = 5'd8,
      ST_TO_RD   = 5'd9,
      ST_RD_WAIT = 5'd10,
      ST_TO_WR1  = 5'd11,
      ST_TO_WR2  = 5'd12,
      ST_DSY_H   = 5'd13,
      ST_DSY_L   = 5'd14,
      ST_NOOP_D  = 5'd15,
      ST_NOOP_E  = 5'd16,
      ST_FIN     = 5'd17
   } state_t;

   state_t      state;
   logic [5:0]  addr_q;
   logic [3:0]  wait_cnt;
   logic        ce_dec;
   logic        wr_dec;
   logic [15:0] din_dec;
   logic [15:0] hdr;
   logic [15:0] cap_src;

   // The ICAP reverses the bit order inside each byte on both I and O.
   function automatic logic [15:0] rev_bytes(input logic [15:0] d);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i]     = d[7 - i];
         r[8 + i] = d[15 - i];
      end
      return r;
   endfunction

   // Type-1 packet, read opcode, one word.
   assign hdr = {3'b001, 2'b01, addr_q, 5'd1};

`ifdef ICAP_INST_EN
   logic [15:0] icap_o_prim;
   logic        icap_busy_prim;

   ICAP_SPARTAN6 u_icap (
      .BUSY  (icap_busy_prim),
      .O     (icap_o_prim),
      .CE    (ICAP_CE),
      .CLK   (CLK),
      .I     (ICAP_I),
      .WRITE (ICAP_WRITE)
   );

   assign cap_src = icap_o_prim;
`else
   assign cap_src = ICAP_O;
`endif

   // Stage 0: per-state pin values. Encodings outside the enum decode as idle.
   always_comb begin
      ce_dec  = 1'b1;
      wr_dec  = 1'b1;
      din_dec = 16'hFFFF;
      case (state)
         ST_DUMMY:   begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'hFFFF; end
         ST_SYNC1:   begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'hAA99; end
         ST_SYNC2:   begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h5566; end
         ST_NOOP_A:  begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h2000; end
         ST_HDR:     begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = hdr;      end
         ST_NOOP_B:  begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h2000; end
         ST_NOOP_C:  begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h2000; end
         // CE goes high before WRITE flips to read.
         ST_ABORT1:  begin ce_dec = 1'b1; wr_dec = 1'b0; din_dec = 16'h2000; end
         ST_TO_RD:   begin ce_dec = 1'b1; wr_dec = 1'b1; din_dec = 16'h2000; end
         ST_RD_WAIT: begin ce_dec = 1'b0; wr_dec = 1'b1; din_dec = 16'hFFFF; end
         ST_TO_WR1:  begin ce_dec = 1'b1; wr_dec = 1'b1; din_dec = 16'hFFFF; end
         ST_TO_WR2:  begin ce_dec = 1'b1; wr_dec = 1'b0; din_dec = 16'hFFFF; end
         ST_DSY_H:   begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h30A1; end
         ST_DSY_L:   begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h000D; end
         ST_NOOP_D:  begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h2000; end
         ST_NOOP_E:  begin ce_dec = 1'b0; wr_dec = 1'b0; din_dec = 16'h2000; end
         default:    begin ce_dec = 1'b1; wr_dec = 1'b1; din_dec = 16'hFFFF; end
      endcase
   end

   // Stage 1: registered pins, sequencer and handshake.
   always_ff @(posedge CLK) begin
      if (MBT_RESET) begin
         state      <= ST_IDLE;
         addr_q     <= 6'd0;
         wait_cnt   <= 4'd0;
         ICAP_CE    <= 1'b1;
         ICAP_WRITE <= 1'b1;
         ICAP_I     <= 16'hFFFF;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         RD_DATA    <= 16'd0;
      end else begin
         ICAP_CE    <= ce_dec;
         ICAP_WRITE <= wr_dec;
         ICAP_I     <= rev_bytes(din_dec);
         DONE       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (RD_REQ) begin
                  addr_q <= REG_ADDR;
                  BUSY   <= 1'b1;
                  state  <= ST_DUMMY;
               end
            end
            ST_DUMMY:  state <= ST_SYNC1;
            ST_SYNC1:  state <= ST_SYNC2;
            ST_SYNC2:  state <= ST_NOOP_A;
            ST_NOOP_A: state <= ST_HDR;
            ST_HDR:    state <= ST_NOOP_B;
            ST_NOOP_B: state <= ST_NOOP_C;
            ST_NOOP_C: state <= ST_ABORT1;
            ST_ABORT1: state <= ST_TO_RD;
            ST_TO_RD: begin
               wait_cnt <= 4'd0;
               state    <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  RD_DATA <= rev_bytes(cap_src);
                  state   <= ST_TO_WR1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ST_TO_WR1: state <= ST_TO_WR2;
            ST_TO_WR2: state <= ST_DSY_H;
            ST_DSY_H:  state <= ST_DSY_L;
            ST_DSY_L:  state <= ST_NOOP_D;
            ST_NOOP_D: state <= ST_NOOP_E;
            ST_NOOP_E: state <= ST_FIN;
            ST_FIN: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icap_reg_reader_spartan6.sv
module tb_icap_reg_reader_spartan6;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b;
   logic [5:0]  addr;
   logic [15:0] icap_o;

   logic        busy_a, done_a, ce_a, wr_a;
   logic [15:0] rdd_a, i_a;
   logic        busy_b, done_b, ce_b, wr_b;
   logic [15:0] rdd_b, i_b;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_viol = 0;
   int bd_viol = 0;

   always #5 clk = ~clk;

   icap_reg_reader_spartan6 #(.RD_WAIT(3)) dut_a (
      .CLK(clk), .MBT_RESET(rst), .RD_REQ(req_a), .REG_ADDR(addr),
      .BUSY(busy_a), .DONE(done_a), .RD_DATA(rdd_a),
      .ICAP_CE(ce_a), .ICAP_WRITE(wr_a), .ICAP_I(i_a), .ICAP_O(icap_o)
   );

   icap_reg_reader_spartan6 #(.RD_WAIT(5)) dut_b (
      .CLK(clk), .MBT_RESET(rst), .RD_REQ(req_b), .REG_ADDR(addr),
      .BUSY(busy_b), .DONE(done_b), .RD_DATA(rdd_b),
      .ICAP_CE(ce_b), .ICAP_WRITE(wr_b), .ICAP_I(i_b), .ICAP_O(icap_o)
   );

   function automatic logic [15:0] brev(input logic [15:0] d);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i]     = d[7 - i];
         r[8 + i] = d[15 - i];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the pin word list a read produces, written from the
   // command sequence a Spartan-6 register read needs.
   typedef struct { logic ce; logic wr; logic [15:0] din; } pin_t;
   pin_t exp_q[$];

   function automatic void push(input logic ce, input logic wr, input logic [15:0] din);
      pin_t p;
      p.ce = ce; p.wr = wr; p.din = din;
      exp_q.push_back(p);
   endfunction

   function automatic void build_model(input logic [15:0] hdr, input int rw);
      exp_q.delete();
      push(0, 0, 16'hFFFF);                    // dummy word
      push(0, 0, 16'hAA99);                    // sync
      push(0, 0, 16'h5566);
      push(0, 0, 16'h2000);                    // noop
      push(0, 0, hdr);                         // read header
      push(0, 0, 16'h2000);
      push(0, 0, 16'h2000);
      push(1, 0, 16'h2000);                    // abort write
      push(1, 1, 16'h2000);                    // turn to read
      for (int k = 0; k < rw; k++) push(0, 1, 16'hFFFF);
      push(1, 1, 16'hFFFF);                    // turn to write
      push(1, 0, 16'hFFFF);
      push(0, 0, 16'h30A1);                    // desync
      push(0, 0, 16'h000D);
      push(0, 0, 16'h2000);
      push(0, 0, 16'h2000);
      push(1, 1, 16'hFFFF);                    // released
   endfunction

   // Runs one read from idle and checks pins, BUSY, DONE timing, header and data.
   task automatic run_read(input bit sel_b, input logic [5:0] a, input logic [15:0] val,
                           input logic [15:0] exp_hdr, input string tag);
      int rw, done_cyc, pin_err, busy_err;
      logic [15:0] got, hdr_seen;
      logic ce, wr, bsy, dn;
      logic [15:0] ii, rd;
      rw = sel_b ? 5 : 3;
      build_model(exp_hdr, rw);
      done_cyc = -1; pin_err = 0; busy_err = 0; got = 16'hxxxx; hdr_seen = 16'hxxxx;
      @(negedge clk);
      addr = a; icap_o = brev(val);
      if (sel_b) req_b = 1'b1; else req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      addr = 6'($urandom);                     // must not affect the latched address
      for (int c = 1; c <= 40; c++) begin
         ce  = sel_b ? ce_b   : ce_a;
         wr  = sel_b ? wr_b   : wr_a;
         ii  = sel_b ? i_b    : i_a;
         bsy = sel_b ? busy_b : busy_a;
         dn  = sel_b ? done_b : done_a;
         rd  = sel_b ? rdd_b  : rdd_a;
         if (c == 1) begin
            if (ce !== 1'b1 || wr !== 1'b1 || ii !== 16'hFFFF) pin_err++;
         end else if (c - 2 < exp_q.size()) begin
            if (ce !== exp_q[c-2].ce || wr !== exp_q[c-2].wr || ii !== brev(exp_q[c-2].din)) begin
               if (pin_err == 0)
                  $display("  %s pin diff at cycle %0d: ce=%b wr=%b i=%h", tag, c, ce, wr, brev(ii));
               pin_err++;
            end
         end
         if (c == 6) hdr_seen = brev(ii);
         if (bsy !== (c <= 16 + rw)) busy_err++;
         if (dn === 1'b1) begin
            done_cyc = c;
            got = rd;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_pins"}, pin_err, 0);
      check({tag, "_busy"}, busy_err, 0);
      check({tag, "_hdr"}, hdr_seen, exp_hdr);
      check({tag, "_done_cycle"}, done_cyc, 17 + rw);
      check({tag, "_rd_data"}, got, val);
   endtask

   // Pin-level protocol monitors.
   logic pce_a = 1'b1, pwr_a = 1'b1, pce_b = 1'b1, pwr_b = 1'b1;
   always @(negedge clk) begin
      if (pce_a === 1'b0 && ce_a === 1'b0 && wr_a !== pwr_a) wr_viol++;
      if (pce_b === 1'b0 && ce_b === 1'b0 && wr_b !== pwr_b) wr_viol++;
      if ((busy_a === 1'b1 && done_a === 1'b1) || (busy_b === 1'b1 && done_b === 1'b1)) bd_viol++;
      pce_a = ce_a; pwr_a = wr_a; pce_b = ce_b; pwr_b = wr_b;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct { logic [5:0] addr; logic [15:0] val; logic [15:0] hdr; bit use_b; } vec_t;
   vec_t tbl[4];

   initial begin
      int dones, t[3], cnt;
      bit drop_next;
      logic [5:0]  ra;
      logic [15:0] rv;

      tbl[0] = '{6'h08, 16'h1234, 16'h2901, 1'b0};
      tbl[1] = '{6'h17, 16'h0001, 16'h2AE1, 1'b1};
      tbl[2] = '{6'h13, 16'hBEEF, 16'h2A61, 1'b0};
      tbl[3] = '{6'h3F, 16'hA5C3, 16'h2FE1, 1'b0};

      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; addr = 6'd0; icap_o = 16'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ce", ce_a, 1'b1);
      check("rst_write", wr_a, 1'b1);
      check("rst_i", i_a, 16'hFFFF);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_rd_data", rdd_a, 16'h0000);
      check("rst_b_i", i_b, 16'hFFFF);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int k = 0; k < 4; k++) begin
         run_read(tbl[k].use_b, tbl[k].addr, tbl[k].val, tbl[k].hdr, $sformatf("tbl%0d", k));
         icap_o = 16'h0;
         repeat (3) @(negedge clk);
         check($sformatf("tbl%0d_hold", k), tbl[k].use_b ? rdd_b : rdd_a, tbl[k].val);
      end

      // Randomized reads against the model
      for (int k = 0; k < 8; k++) begin
         ra = 6'($urandom);
         rv = 16'($urandom);
         run_read(1'b0, ra, rv, {3'b001, 2'b01, ra, 5'd1}, $sformatf("rnd%0d", k));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // RD_REQ held high: three reads, 20 cycles apart
      @(negedge clk);
      addr = 6'h08; icap_o = brev(16'h5A5A); req_a = 1'b1;
      dones = 0; drop_next = 0; t[0] = -1; t[1] = -1; t[2] = -1;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (drop_next) begin req_a = 1'b0; drop_next = 0; end
         if (done_a === 1'b1) begin
            if (dones < 3) t[dones] = c;
            dones++;
            if (dones == 2) drop_next = 1;
         end
      end
      req_a = 1'b0;
      check("held_done_count", dones, 3);
      check("held_first_done", t[0], 20);
      check("held_gap1", t[1] - t[0], 20);
      check("held_gap2", t[2] - t[1], 20);
      check("held_rd_data", rdd_a, 16'h5A5A);

      // Reset in the read-wait window
      @(negedge clk);
      addr = 6'h17; icap_o = brev(16'hCAFE); req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_in_read", {ce_a, wr_a}, 2'b01);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ce", ce_a, 1'b1);
      check("mid_rst_write", wr_a, 1'b1);
      check("mid_rst_i", i_a, 16'hFFFF);
      check("mid_rst_busy", busy_a, 1'b0);
      check("mid_rst_done", done_a, 1'b0);
      check("mid_rst_rd_data", rdd_a, 16'h0000);
      rst = 1'b0;
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_a === 1'b1) cnt++;
      end
      check("mid_no_done", cnt, 0);
      run_read(1'b0, 6'h17, 16'h0C0F, 16'h2AE1, "after_rst");

      check("write_stable_ce_low", wr_viol, 0);
      check("busy_done_exclusive", bd_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
